// File: rtl/scoreboard_hazard_unit_pkg.sv
// scoreboard_hazard_unit_pkg: default widths and the latency classes the control unit drives onto id_lat
package scoreboard_hazard_unit_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_MAX_LAT = 4;
  localparam int DEF_LAT_W = 3;
  localparam int DEF_SCNT_W = 16;
  localparam logic [DEF_LAT_W-1:0] LAT_ALU = 3'd1;
  localparam logic [DEF_LAT_W-1:0] LAT_LOAD = 3'd2;
  localparam logic [DEF_LAT_W-1:0] LAT_MUL = 3'd4;
endpackage

// File: rtl/scoreboard_hazard_unit_sb_reg_counter.sv
// sb_reg_counter: per-register countdown; load wins over decrement, stops at zero
//   clk, reset (async active-low clear), load, load_val -> cnt
module sb_reg_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: per-register latency scoreboard driving ID-stage stall/bubble and a stall counter
//   in:  clk, reset (async active-low), id_valid, id_rs/id_rt with id_uses_rs/id_uses_rt,
//        id_wr_en/id_rd, id_lat, flush
//   out: stall, pc_write, ifid_write, idex_bubble, stall_count (saturating)
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int LAT_W = DEF_LAT_W,
  parameter int FWD_EN = 1,
  parameter int SCNT_W = DEF_SCNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              flush,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [SCNT_W-1:0] stall_count
);
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] lat_c;
  logic haz_rs, haz_rt, waw, issue;
  // with forwarding a count of 1 means the value reaches the bypass in time
  function automatic logic src_haz(input logic [REG_AW-1:0] r, input logic [LAT_W-1:0] c);
    return (r != '0) && ((FWD_EN != 0) ? (c > LAT_W'(1)) : (c != '0));
  endfunction
  assign cnt[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    sb_reg_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk(clk),
      .reset(reset),
      .load(issue && (id_rd == REG_AW'(i))),
      .load_val(lat_c),
      .cnt(cnt[i])
    );
  end
  assign lat_c = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
  assign haz_rs = id_uses_rs && src_haz(id_rs, cnt[id_rs]);
  assign haz_rt = id_uses_rt && src_haz(id_rt, cnt[id_rt]);
  // a younger write must not land before an older, slower one to the same register
  assign waw = id_wr_en && (id_rd != '0) && (cnt[id_rd] > lat_c);
  assign stall = id_valid && !flush && (haz_rs || haz_rt || waw);
  assign issue = id_valid && !stall && !flush && id_wr_en && (id_rd != '0);
  assign pc_write = !stall;
  assign ifid_write = !stall;
  assign idex_bubble = stall || flush;
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: forwarding and non-forwarding units driven side by side against a scoreboard model
module tb_scoreboard_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  logic id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_wr_en = 1'b0, flush = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [2:0] id_lat = '0;
  logic st [2];
  logic pcw [2];
  logic ifw [2];
  logic bub [2];
  logic [15:0] sc [2];
  int checks = 0, errors = 0;
  int mc [2][32];
  int msc [2];
  int a, b;

  always #5 clk = ~clk;

  scoreboard_hazard_unit #(.FWD_EN(1)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_lat(id_lat), .flush(flush), .stall(st[0]), .pc_write(pcw[0]), .ifid_write(ifw[0]),
    .idex_bubble(bub[0]), .stall_count(sc[0])
  );
  scoreboard_hazard_unit #(.FWD_EN(0)) u_nof (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_lat(id_lat), .flush(flush), .stall(st[1]), .pc_write(pcw[1]), .ifid_write(ifw[1]),
    .idex_bubble(bub[1]), .stall_count(sc[1])
  );

  task automatic chk(string n, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", n, d, act, exp);
    end
  endtask

  function automatic int latc();
    return (id_lat > 3'd4) ? 4 : int'(id_lat);
  endfunction

  // model DUT 0 forwards, DUT 1 does not
  function automatic bit hz(int d, int r);
    if (r == 0) return 1'b0;
    return (d == 0) ? (mc[d][r] > 1) : (mc[d][r] != 0);
  endfunction

  function automatic bit m_stall(int d);
    return id_valid && !flush &&
      ((id_uses_rs && hz(d, int'(id_rs))) || (id_uses_rt && hz(d, int'(id_rt))) ||
       (id_wr_en && id_rd != 0 && mc[d][id_rd] > latc()));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (mc[d, r]) mc[d][r] = 0;
      msc[0] = 0;
      msc[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit s, iss;
        s = m_stall(d);
        iss = id_valid && !s && !flush && id_wr_en && id_rd != 0;
        for (int r = 1; r < 32; r++) if (mc[d][r] > 0) mc[d][r]--;
        if (iss) mc[d][id_rd] = latc();
        if (s && msc[d] < 65535) msc[d]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit s;
      s = m_stall(d);
      chk("stall", d, int'(st[d]), int'(s));
      chk("pc_write", d, int'(pcw[d]), int'(!s));
      chk("ifid_write", d, int'(ifw[d]), int'(!s));
      chk("idex_bubble", d, int'(bub[d]), int'(s || flush));
      chk("stall_count", d, int'(sc[d]), msc[d]);
    end
  end

  task automatic set_i(bit v, bit urs, int rs, bit urt, int rt, bit wr, int rd, int lat, bit fl);
    id_valid = v;
    id_uses_rs = urs;
    id_rs = 5'(rs);
    id_uses_rt = urt;
    id_rt = 5'(rt);
    id_wr_en = wr;
    id_rd = 5'(rd);
    id_lat = 3'(lat);
    flush = fl;
  endtask

  // hold the ID instruction until both units accept it, counting stall cycles of each
  task automatic hold(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n0 += int'(st[0]);
      n1 += int'(st[1]);
      if (!st[0] && !st[1]) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL hold_timeout: still stalled after 12 cycles, required release");
  endtask

  initial begin
    reset = 1'b0;
    set_i(1, 1, 5, 1, 8, 1, 9, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", d, int'(st[d]), 0);
      chk("rst_pc_write", d, int'(pcw[d]), 1);
      chk("rst_bubble", d, int'(bub[d]), 0);
      chk("rst_count", d, int'(sc[d]), 0);
    end
    reset = 1'b1;
    set_i(1, 0, 0, 0, 0, 1, 8, 2, 0);
    hold(a, b);
    chk("lw_issue", 0, a, 0);
    chk("lw_issue", 1, b, 0);
    set_i(1, 1, 8, 1, 8, 1, 9, 1, 0);
    hold(a, b);
    chk("load_use", 0, a, 1);
    chk("load_use", 1, b, 2);
    chk("load_use_count", 0, int'(sc[0]), 1);
    chk("load_use_count", 1, int'(sc[1]), 2);
    set_i(1, 0, 0, 0, 0, 1, 5, 4, 0);
    hold(a, b);
    set_i(1, 1, 5, 0, 0, 1, 10, 1, 0);
    hold(a, b);
    chk("mul_use", 0, a, 3);
    chk("mul_use", 1, b, 4);
    set_i(1, 0, 0, 0, 0, 1, 5, 4, 0);
    hold(a, b);
    set_i(1, 0, 0, 0, 0, 1, 5, 1, 0);
    hold(a, b);
    chk("waw", 0, a, 3);
    chk("waw", 1, b, 3);
    set_i(1, 0, 0, 0, 0, 1, 6, 7, 0);
    hold(a, b);
    set_i(1, 0, 0, 1, 6, 1, 11, 1, 0);
    hold(a, b);
    chk("lat_clamp", 0, a, 3);
    chk("lat_clamp", 1, b, 4);
    set_i(1, 0, 0, 0, 0, 1, 5, 4, 0);
    hold(a, b);
    set_i(1, 1, 5, 0, 0, 1, 12, 1, 1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("flush_stall", d, int'(st[d]), 0);
      chk("flush_bubble", d, int'(bub[d]), 1);
    end
    @(posedge clk);
    #1;
    set_i(1, 1, 5, 0, 0, 1, 12, 1, 0);
    hold(a, b);
    chk("after_flush", 0, a, 2);
    chk("after_flush", 1, b, 3);
    set_i(1, 0, 0, 0, 0, 1, 0, 4, 0);
    hold(a, b);
    set_i(1, 1, 0, 1, 0, 1, 13, 1, 0);
    hold(a, b);
    chk("r0_untracked", 0, a, 0);
    chk("r0_untracked", 1, b, 0);
    set_i(1, 0, 0, 0, 0, 1, 5, 4, 0);
    hold(a, b);
    set_i(1, 1, 5, 0, 0, 1, 14, 1, 0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("mid_stall", d, int'(st[d]), 1);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_stall", d, int'(st[d]), 0);
      chk("async_rst_pc_write", d, int'(pcw[d]), 1);
      chk("async_rst_count", d, int'(sc[d]), 0);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    hold(a, b);
    chk("post_rst_issue", 0, a, 0);
    chk("post_rst_issue", 1, b, 0);
    // self-dependent mul keeps the non-forwarding unit stalled 4 of every 5 cycles
    set_i(1, 1, 5, 0, 0, 1, 5, 4, 0);
    repeat (83000) @(posedge clk);
    #1;
    chk("saturate", 1, int'(sc[1]), 65535);
    set_i(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
